l2_control: RTL and testbench

- Control FSM for the 2-way set-associative L2. It sits directly upstream of the per-way tag/valid/dirty/LRU/data storage arrays and drives their index, load strobes and write data.
- The arrays have combinational read and synchronous write on load. This block compares their outputs against the request, and sequences writeback and fill through physical memory.
- It also keeps saturating hit, miss and writeback counters for performance debug.

---
 rtl/l2_types.sv | 42 ++++
 rtl/l2_perf_counter.sv | 35 +++
 rtl/l2_control.sv | 202 ++++++++++++++++++++
 tb/tb_l2_control.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_types.sv
// Shared types and helpers for the 2-way set-associative L2 control path.
// Holds the address field geometry, the FSM state encoding, the data-array
// input mux encoding, the registered victim record and the address-field
// extraction helpers used by l2_control.
package l2_types;

  localparam int s_offset = 5;                      // 32-byte line
  localparam int s_index  = 3;                      // 8 sets
  localparam int s_tag    = 32 - s_offset - s_index;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_e;

  // Data-array input mux encoding.
  localparam logic DSEL_WRITE = 1'b0;
  localparam logic DSEL_FILL  = 1'b1;

  // Victim way chosen on a miss, plus a marker that a refill is in flight so
  // the post-fill re-check is not counted as a second miss or as a hit.
  typedef struct packed {
    logic refill;
    logic way;
  } victim_t;

  function automatic logic [s_tag-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: s_tag];
  endfunction

  function automatic logic [s_index-1:0] addr_index(input logic [31:0] addr);
    return addr[s_offset +: s_index];
  endfunction

  function automatic logic [31:0] line_addr(input logic [s_tag-1:0]   tag,
                                            input logic [s_index-1:0] idx);
    return {tag, idx, {s_offset{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_perf_counter.sv
// Saturating performance counter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears to 0)
//   incr       : count one event this cycle
//   count      : current value; holds at all-ones instead of wrapping
module l2_perf_counter #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             incr,
  output logic [width-1:0] count
);

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (incr && (count_q != '1)) begin
      count_d = count_q + width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_control.sv
// Control FSM for the 2-way set-associative L2.
// Compares the per-way tag/valid outputs of the storage arrays against the
// upstream request, answers hits directly, and sequences victim writeback and
// line fill through physical memory. Array outputs are combinational, array
// loads happen on the clock edge while a load strobe is high.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   mem_read/mem_write/mem_address     : upstream request (held until mem_resp)
//   mem_resp                           : one-cycle upstream completion pulse
//   pmem_read/pmem_write/pmem_address  : physical memory line transfer request
//   pmem_resp                          : physical memory completion pulse
//   tag0_out/tag1_out/valid_out/dirty_out/lru_out : array read data
//   index/tag_in/valid_in/dirty_in/lru_in         : array index and write data
//   load_tag/load_valid/load_dirty/load_data/load_lru : array load strobes
//   data_sel                           : data-array input mux (write merge / fill)
//   way_sel                            : read-data way mux toward upstream
//   hit_count/miss_count/wb_count      : saturating performance counters
module l2_control
  import l2_types::*;
#(
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [31:0]          pmem_address,
  input  logic                 pmem_resp,
  input  logic [s_tag-1:0]     tag0_out,
  input  logic [s_tag-1:0]     tag1_out,
  input  logic [1:0]           valid_out,
  input  logic [1:0]           dirty_out,
  input  logic                 lru_out,
  output logic [s_index-1:0]   index,
  output logic [s_tag-1:0]     tag_in,
  output logic [1:0]           load_tag,
  output logic [1:0]           load_valid,
  output logic [1:0]           load_dirty,
  output logic [1:0]           load_data,
  output logic                 valid_in,
  output logic                 dirty_in,
  output logic                 lru_in,
  output logic                 load_lru,
  output logic                 data_sel,
  output logic                 way_sel,
  output logic [cnt_width-1:0] hit_count,
  output logic [cnt_width-1:0] miss_count,
  output logic [cnt_width-1:0] wb_count
);

  state_e          state_q, state_d;
  victim_t         victim_q, victim_d;
  logic [1:0]      hit;
  logic            hit_way;
  logic            miss_way;
  logic            hit_incr, miss_incr, wb_incr;
  logic [s_tag-1:0] req_tag;

  // Byte-offset bits never affect line-level control.
  logic unused_offset;
  assign unused_offset = ^mem_address[s_offset-1:0];

  assign req_tag = addr_tag(mem_address);
  assign index   = addr_index(mem_address);
  assign tag_in  = req_tag;

  assign hit[0]  = valid_out[0] && (tag0_out == req_tag);
  assign hit[1]  = valid_out[1] && (tag1_out == req_tag);
  assign hit_way = hit[1];
  assign way_sel = hit[1];

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = line_addr(req_tag, index);
    load_tag     = 2'b00;
    load_valid   = 2'b00;
    load_dirty   = 2'b00;
    load_data    = 2'b00;
    valid_in     = 1'b0;
    dirty_in     = 1'b0;
    lru_in       = 1'b0;
    load_lru     = 1'b0;
    data_sel     = DSEL_WRITE;
    hit_incr     = 1'b0;
    miss_incr    = 1'b0;
    wb_incr      = 1'b0;
    miss_way     = 1'b0;

    // Fill an empty way first; only evict by LRU when both ways are valid.
    if (!valid_out[0]) begin
      miss_way = 1'b0;
    end else if (!valid_out[1]) begin
      miss_way = 1'b1;
    end else begin
      miss_way = lru_out;
    end

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (|hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          // A simultaneous read and write is served as a write.
          if (mem_write) begin
            load_data[hit_way]  = 1'b1;
            load_dirty[hit_way] = 1'b1;
            dirty_in            = 1'b1;
            data_sel            = DSEL_WRITE;
          end
          // The re-check after a fill is the same access, not a new hit.
          hit_incr        = !victim_q.refill;
          victim_d.refill = 1'b0;
          state_d         = IDLE;
        end else begin
          miss_incr = !victim_q.refill;
          victim_d  = '{refill: 1'b1, way: miss_way};
          if (valid_out[miss_way] && dirty_out[miss_way]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = FILL;
          end
        end
      end

      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = line_addr(victim_q.way ? tag1_out : tag0_out, index);
        if (pmem_resp) begin
          wb_incr = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data[victim_q.way]  = 1'b1;
          load_tag[victim_q.way]   = 1'b1;
          load_valid[victim_q.way] = 1'b1;
          load_dirty[victim_q.way] = 1'b1;
          data_sel                 = DSEL_FILL;
          valid_in                 = 1'b1;
          dirty_in                 = 1'b0;
          state_d                  = COMPARE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  l2_perf_counter #(.width(cnt_width)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .incr  (hit_incr),
    .count (hit_count)
  );

  l2_perf_counter #(.width(cnt_width)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .incr  (miss_incr),
    .count (miss_count)
  );

  l2_perf_counter #(.width(cnt_width)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .incr  (wb_incr),
    .count (wb_count)
  );

endmodule

// File: tb/tb_l2_control.sv
// Self-checking bench for l2_control. Emulates the per-way storage arrays,
// answers physical memory with random latency, and predicts each access from
// a set/way cache model. A second instance with 3-bit counters shares all
// inputs so counter saturation is reached in a short run.
module tb_l2_control;

  logic        clk;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic        pmem_resp;

  logic        mem_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [23:0] tag0_out, tag1_out;
  logic [1:0]  valid_out, dirty_out;
  logic        lru_out;
  logic [2:0]  index;
  logic [23:0] tag_in;
  logic [1:0]  load_tag, load_valid, load_dirty, load_data;
  logic        valid_in, dirty_in, lru_in, load_lru, data_sel, way_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  // Second instance: only its counters are observed.
  logic        s_mem_resp, s_pmem_read, s_pmem_write;
  logic [31:0] s_pmem_address;
  logic [2:0]  s_index;
  logic [23:0] s_tag_in;
  logic [1:0]  s_load_tag, s_load_valid, s_load_dirty, s_load_data;
  logic        s_valid_in, s_dirty_in, s_lru_in, s_load_lru, s_data_sel, s_way_sel;
  logic [2:0]  s_hit_count, s_miss_count, s_wb_count;

  int tests  = 0;
  int failed = 0;

  l2_control #(.cnt_width(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .tag0_out(tag0_out), .tag1_out(tag1_out), .valid_out(valid_out),
    .dirty_out(dirty_out), .lru_out(lru_out), .index(index), .tag_in(tag_in),
    .load_tag(load_tag), .load_valid(load_valid), .load_dirty(load_dirty),
    .load_data(load_data), .valid_in(valid_in), .dirty_in(dirty_in),
    .lru_in(lru_in), .load_lru(load_lru), .data_sel(data_sel), .way_sel(way_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  l2_control #(.cnt_width(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(s_mem_resp), .pmem_read(s_pmem_read),
    .pmem_write(s_pmem_write), .pmem_address(s_pmem_address), .pmem_resp(pmem_resp),
    .tag0_out(tag0_out), .tag1_out(tag1_out), .valid_out(valid_out),
    .dirty_out(dirty_out), .lru_out(lru_out), .index(s_index), .tag_in(s_tag_in),
    .load_tag(s_load_tag), .load_valid(s_load_valid), .load_dirty(s_load_dirty),
    .load_data(s_load_data), .valid_in(s_valid_in), .dirty_in(s_dirty_in),
    .lru_in(s_lru_in), .load_lru(s_load_lru), .data_sel(s_data_sel),
    .way_sel(s_way_sel), .hit_count(s_hit_count), .miss_count(s_miss_count),
    .wb_count(s_wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- storage array emulation ----------------
  logic [23:0] tag0_arr [8];
  logic [23:0] tag1_arr [8];
  logic [1:0]  valid_arr [8];
  logic [1:0]  dirty_arr [8];
  logic        lru_arr [8];

  logic        preset_en = 1'b0;
  logic        preset_all = 1'b0;
  logic [2:0]  p_set;
  logic [1:0]  p_valid, p_dirty;
  logic [23:0] p_tag0, p_tag1;
  logic        p_lru;

  assign tag0_out  = tag0_arr[index];
  assign tag1_out  = tag1_arr[index];
  assign valid_out = valid_arr[index];
  assign dirty_out = dirty_arr[index];
  assign lru_out   = lru_arr[index];

  always @(posedge clk) begin
    if (preset_en) begin
      if (preset_all) begin
        for (int s = 0; s < 8; s++) begin
          valid_arr[s] <= 2'b00; dirty_arr[s] <= 2'b00; lru_arr[s] <= 1'b0;
          tag0_arr[s] <= '0; tag1_arr[s] <= '0;
        end
      end else begin
        valid_arr[p_set] <= p_valid; dirty_arr[p_set] <= p_dirty;
        tag0_arr[p_set] <= p_tag0; tag1_arr[p_set] <= p_tag1; lru_arr[p_set] <= p_lru;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (load_valid[w]) valid_arr[index][w] <= valid_in;
        if (load_dirty[w]) dirty_arr[index][w] <= dirty_in;
      end
      if (load_tag[0]) tag0_arr[index] <= tag_in;
      if (load_tag[1]) tag1_arr[index] <= tag_in;
      if (load_lru)    lru_arr[index]  <= lru_in;
    end
  end

  // ---------------- reference cache model ----------------
  logic [1:0]  m_valid [8];
  logic [1:0]  m_dirty [8];
  logic [23:0] m_tag [8][2];
  logic        m_lru [8];      // least recently used way
  int n_hit = 0, n_miss = 0, n_wb = 0;

  typedef struct packed {
    logic        hit;
    logic        way;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
  } exp_t;

  typedef struct {
    logic        timeout;
    int          lat;
    int          fill_cycle;
    logic        did_wb;
    logic [31:0] wb_addr;
    logic        did_fill;
    logic [31:0] fill_addr;
    logic [10:0] fill_vec;
    logic [10:0] resp_vec;
    logic        resp_din;
    logic        resp_dsel;
    logic        both_err;
    logic        stray;
    logic        resp_stuck;
  } obs_t;

  typedef struct {
    logic        do_preset;
    logic [2:0]  p_set;
    logic [1:0]  p_valid, p_dirty;
    logic [23:0] p_tag0, p_tag1;
    logic        p_lru;
    logic [31:0] addr;
    logic        rd, wr;
    logic        e_hit, e_way, e_wb;
    logic [31:0] e_wb_addr, e_fill_addr;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic check_counters(input string nm);
    check({nm, " hit_count"},   32'(hit_count),    32'(sat(n_hit, 16'hFFFF)));
    check({nm, " miss_count"},  32'(miss_count),   32'(sat(n_miss, 16'hFFFF)));
    check({nm, " wb_count"},    32'(wb_count),     32'(sat(n_wb, 16'hFFFF)));
    check({nm, " small hit"},   32'(s_hit_count),  32'(sat(n_hit, 7)));
    check({nm, " small miss"},  32'(s_miss_count), 32'(sat(n_miss, 7)));
    check({nm, " small wb"},    32'(s_wb_count),   32'(sat(n_wb, 7)));
  endtask

  task automatic preset(input logic [2:0] s, input logic [1:0] v, input logic [1:0] d,
                        input logic [23:0] t0, input logic [23:0] t1, input logic l);
    p_set = s; p_valid = v; p_dirty = d; p_tag0 = t0; p_tag1 = t1; p_lru = l;
    preset_en = 1'b1;
    @(posedge clk); #1;
    preset_en = 1'b0;
    m_valid[s] = v; m_dirty[s] = d; m_tag[s][0] = t0; m_tag[s][1] = t1; m_lru[s] = l;
  endtask

  task automatic clear_arrays();
    preset_all = 1'b1; preset_en = 1'b1;
    @(posedge clk); #1;
    preset_en = 1'b0; preset_all = 1'b0;
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 2'b00; m_dirty[s] = 2'b00; m_lru[s] = 1'b0;
      m_tag[s][0] = '0; m_tag[s][1] = '0;
    end
  endtask

  // Predict one access from the cache rules, then update the model.
  task automatic predict(input logic [31:0] addr, input logic wr, output exp_t e);
    logic [2:0]  s;
    logic [23:0] t;
    logic        v;
    s = addr[7:5];
    t = addr[31:8];
    e = '0;
    if (m_valid[s][0] && m_tag[s][0] == t) begin
      e.hit = 1'b1; e.way = 1'b0;
    end else if (m_valid[s][1] && m_tag[s][1] == t) begin
      e.hit = 1'b1; e.way = 1'b1;
    end
    if (e.hit) begin
      n_hit++;
      if (wr) m_dirty[s][e.way] = 1'b1;
      m_lru[s] = ~e.way;
    end else begin
      v = !m_valid[s][0] ? 1'b0 : (!m_valid[s][1] ? 1'b1 : m_lru[s]);
      e.way       = v;
      e.wb        = m_valid[s][v] && m_dirty[s][v];
      e.wb_addr   = {m_tag[s][v], s, 5'b00000};
      e.fill_addr = {t, s, 5'b00000};
      n_miss++;
      if (e.wb) n_wb++;
      m_valid[s][v] = 1'b1; m_tag[s][v] = t; m_dirty[s][v] = wr; m_lru[s] = ~v;
    end
  endtask

  // Run one upstream access; called and returns at 1 time unit after a rising
  // edge with the DUT idle. Cycle 0 is the cycle the request is first seen.
  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           output obs_t o);
    int   wait_cnt;
    logic done;
    o.timeout = 1'b1; o.lat = 0; o.fill_cycle = 0; o.did_wb = 1'b0; o.wb_addr = '0;
    o.did_fill = 1'b0; o.fill_addr = '0; o.fill_vec = '0; o.resp_vec = '0;
    o.resp_din = 1'b0; o.resp_dsel = 1'b0; o.both_err = 1'b0; o.stray = 1'b0;
    o.resp_stuck = 1'b0;
    done = 1'b0;
    wait_cnt = $urandom_range(0, 3);
    mem_address = addr; mem_read = rd; mem_write = wr;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (wait_cnt == 0) begin
          pmem_resp = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      #1;
      if (pmem_read && pmem_write) o.both_err = 1'b1;
      if (pmem_write) begin o.did_wb = 1'b1; o.wb_addr = pmem_address; end
      if (pmem_read)  begin o.did_fill = 1'b1; o.fill_addr = pmem_address; end
      if (pmem_read && pmem_resp) begin
        o.fill_cycle = c;
        o.fill_vec = {load_tag, load_valid, load_dirty, load_data, valid_in, dirty_in, data_sel};
      end else if (mem_resp) begin
        o.timeout = 1'b0; o.lat = c;
        o.resp_vec = {load_data, load_dirty, load_tag, load_valid, load_lru, lru_in, way_sel};
        o.resp_din = dirty_in; o.resp_dsel = data_sel;
        done = 1'b1;
      end else if (|{load_tag, load_valid, load_dirty, load_data, load_lru}) begin
        o.stray = 1'b1;
      end
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    #1;
    o.resp_stuck = mem_resp;
  endtask

  task automatic compare_access(input string nm, input obs_t o, input exp_t e, input logic wr);
    logic [1:0]  m;
    logic [10:0] exp_resp;
    m = e.way ? 2'b10 : 2'b01;
    exp_resp = {(wr ? m : 2'b00), (wr ? m : 2'b00), 4'b0000, 1'b1, ~e.way, e.way};
    check({nm, " timeout"}, o.timeout, 1'b0);
    if (e.hit) check({nm, " hit latency"}, o.lat, 1);
    else       check({nm, " miss latency"}, o.lat, o.fill_cycle + 1);
    check({nm, " writeback seen"}, o.did_wb, e.wb);
    if (e.wb) check({nm, " writeback addr"}, o.wb_addr, e.wb_addr);
    check({nm, " fill seen"}, o.did_fill, !e.hit);
    if (!e.hit) begin
      check({nm, " fill addr"}, o.fill_addr, e.fill_addr);
      check({nm, " fill strobes"}, 32'(o.fill_vec), 32'({m, m, m, m, 3'b101}));
    end
    check({nm, " resp strobes"}, 32'(o.resp_vec), 32'(exp_resp));
    if (wr) check({nm, " write dirty_in/data_sel"}, {o.resp_din, o.resp_dsel}, 2'b10);
    check({nm, " pmem read+write overlap"}, o.both_err, 1'b0);
    check({nm, " stray load strobe"}, o.stray, 1'b0);
    check({nm, " mem_resp one cycle"}, o.resp_stuck, 1'b0);
    check_counters(nm);
  endtask

  vec_t vecs [11];

  initial begin
    obs_t o;
    exp_t e;
    exp_t te;
    logic found;
    logic [23:0] tag_pool [4];

    vecs[0]  = '{1'b1, 3'd2, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h0000_0040, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0040};
    vecs[1]  = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h0000_0040, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h1234_5640, 1'b0, 1'b1,
                 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5640};
    vecs[3]  = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h1234_5640, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'd2, 2'b11, 2'b10, 24'h000001, 24'hABCDEF, 1'b1, 32'h5555_555F, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b1, 32'hABCD_EF40, 32'h5555_5540};
    vecs[5]  = '{1'b1, 3'd5, 2'b11, 2'b01, 24'h111111, 24'h222222, 1'b0, 32'h3333_33A0, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b1, 32'h1111_11A0, 32'h3333_33A0};
    vecs[6]  = '{1'b1, 3'd5, 2'b11, 2'b00, 24'h111111, 24'h222222, 1'b1, 32'h4444_44A0, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b0, 32'h0, 32'h4444_44A0};
    vecs[7]  = '{1'b1, 3'd7, 2'b10, 2'b10, 24'h0, 24'h777777, 1'b1, 32'h8888_88E0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h8888_88E0};
    vecs[8]  = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h8888_88E0, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h8888_88EC, 1'b1, 1'b0,
                 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[10] = '{1'b0, 3'd0, 2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 32'h7777_77FF, 1'b1, 1'b0,
                 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};

    tag_pool[0] = 24'h000010; tag_pool[1] = 24'hABCDEF;
    tag_pool[2] = 24'h123456; tag_pool[3] = 24'h00FF00;

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; pmem_resp = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    check("reset mem_resp", mem_resp, 1'b0);
    check("reset pmem_read", pmem_read, 1'b0);
    check("reset pmem_write", pmem_write, 1'b0);
    check("reset load strobes", {load_tag, load_valid, load_dirty, load_data, load_lru}, 9'h0);
    check_counters("reset");

    clear_arrays();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_preset)
        preset(vecs[i].p_set, vecs[i].p_valid, vecs[i].p_dirty,
               vecs[i].p_tag0, vecs[i].p_tag1, vecs[i].p_lru);
      predict(vecs[i].addr, vecs[i].wr, e);
      te = '0;
      te.hit = vecs[i].e_hit; te.way = vecs[i].e_way; te.wb = vecs[i].e_wb;
      te.wb_addr = vecs[i].e_wb_addr; te.fill_addr = vecs[i].e_fill_addr;
      do_access(vecs[i].addr, vecs[i].rd, vecs[i].wr, o);
      compare_access($sformatf("vec%0d", i), o, te, vecs[i].wr);
    end

    // Reset while a fill is outstanding.
    mem_address = 32'h9999_99C0; mem_read = 1'b1; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (pmem_read) found = 1'b1;
    end
    check("rst_fill reached fill", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_fill pmem_read", pmem_read, 1'b0);
    check("rst_fill pmem_write", pmem_write, 1'b0);
    check("rst_fill miss_count", 32'(miss_count), 32'd0);
    check("rst_fill hit_count", 32'(hit_count), 32'd0);
    pmem_resp = 1'b1; mem_read = 1'b0;
    #1;
    check("rst_fill load strobes", {load_tag, load_valid, load_dirty, load_data, load_lru}, 9'h0);
    check("rst_fill mem_resp", mem_resp, 1'b0);
    @(posedge clk); #1;
    check("rst_fill valid untouched", valid_arr[6], m_valid[6]);
    check("rst_fill tag untouched", tag0_arr[6], m_tag[6][0]);
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    n_hit = 0; n_miss = 0; n_wb = 0;
    @(posedge clk); #1;
    check("rst_fill idle no pmem", {pmem_read, pmem_write, mem_resp}, 3'b000);

    // Repeated hits drive the 3-bit counter into saturation.
    for (int i = 0; i < 10; i++) begin
      predict(32'h5555_5540, 1'b0, e);
      do_access(32'h5555_5540, 1'b1, 1'b0, o);
      compare_access($sformatf("sat%0d", i), o, e, 1'b0);
    end
    check("sat small hit_count holds", 32'(s_hit_count), 32'h7);

    // Randomized accesses over a few conflicting sets and tags.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic        rd, wr;
      int          k;
      a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      k = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0);
      predict(a, wr, e);
      do_access(a, rd, wr, o);
      compare_access($sformatf("rnd%0d", i), o, e, wr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
